// File: rtl/avalon_ram_slave_if.sv
// Avalon-MM bus bundle between mips_cpu_bus (master) and avalon_ram_slave.
interface avalon_ram_slave_if;
  logic [31:0] address;
  logic        write;
  logic        read;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    output address, write, read, writedata, byteenable,
    input  waitrequest, readdata
  );

  modport slave (
    input  address, write, read, writedata, byteenable,
    output waitrequest, readdata
  );
endinterface

// File: rtl/avalon_ram_slave.sv
// Word-organised Avalon-MM slave RAM with programmable wait states and sticky protocol-error flag.
// Optional AVALON_RAM_RANDOM_WAIT_EN adds LFSR-jittered wait states.
module avalon_ram_slave #(
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int          DEPTH       = 1024,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  avalon_ram_slave_if.slave bus,
  output logic              error
);
  localparam int AW    = $clog2(DEPTH);
  localparam int LANES = 4;

  typedef enum logic [1:0] {IDLE, WAIT, ACCEPT} state_t;

  state_t          state, state_d;
  logic [3:0]      cnt, cnt_d, w_eff, w_m2;
  logic            req, acc, perr, wr_en, rd_en, err_d;
  logic [31:0]     rd_word;
  logic [AW-1:0]   idx;

`ifdef AVALON_RAM_RANDOM_WAIT_EN
  logic [7:0] lfsr;
  logic [4:0] w_sum;

  // Fibonacci taps 8,6,5,4; stepped once per completed transfer so W is stable mid-transfer
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   lfsr <= 8'hA5;
    else if (acc) lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign w_sum = 5'(WAIT_CYCLES) + {3'b000, lfsr[1:0]};
  assign w_eff = (w_sum > 5'd15) ? 4'd15 : w_sum[3:0];
`else
  assign w_eff = 4'(WAIT_CYCLES);
`endif

  assign w_m2 = w_eff - 4'd2;
  assign req  = bus.read | bus.write;
  assign perr = (bus.read & bus.write) | (bus.address[1:0] != 2'b00) |
                (bus.write & (bus.byteenable == 4'b0000));

  // The request cycle itself counts as the first wait state, so W=1 goes straight
  // to ACCEPT and W=0 completes in IDLE without leaving it.
  assign acc   = reset & req & ((state == ACCEPT) | ((state == IDLE) & (w_eff == 4'd0)));
  assign wr_en = acc & bus.write & ~perr;
  assign rd_en = acc & bus.read & ~perr;

  assign bus.waitrequest = ~reset | (req & ~acc);
  assign bus.readdata    = rd_en ? rd_word : '0;

  assign idx = AW'((bus.address - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state;
    cnt_d   = '0;
    err_d   = error;
    case (state)
      IDLE: begin
        if (req && w_eff == 4'd1)     state_d = ACCEPT;
        else if (req && w_eff > 4'd1) state_d = WAIT;
      end
      WAIT: begin
        if (!req) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else if (cnt == w_m2) begin
          state_d = ACCEPT;
        end else begin
          cnt_d = cnt + 4'd1;
        end
      end
      ACCEPT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (acc && perr) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      error <= 1'b0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      error <= err_d;
    end
  end

  // One byte-wide array per lane; contents survive reset
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [7:0] ram [DEPTH];

    always_ff @(posedge clk) begin
      if (wr_en && bus.byteenable[l]) ram[idx] <= bus.writedata[8*l +: 8];
    end

    assign rd_word[8*l +: 8] = ram[idx];
  end
endmodule

// File: tb/tb_avalon_ram_slave.sv
// Directed bench: three instances (W=2, W=0, W=4) share stimulus; sel routes requests and outputs.
module tb_avalon_ram_slave;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  sel;
  logic        rd, wr;
  logic [31:0] address, writedata;
  logic [3:0]  byteenable;
  logic        err_w2, err_w0, err_w4;
  logic        waitreq_m;
  logic [31:0] readdata_m;
  int          n_chk = 0;
  int          n_fail = 0;
  int          w;
  logic [31:0] r;

  always #5 clk = ~clk;

  avalon_ram_slave_if bus_w2();
  avalon_ram_slave_if bus_w0();
  avalon_ram_slave_if bus_w4();

  assign bus_w2.address = address;   assign bus_w0.address = address;   assign bus_w4.address = address;
  assign bus_w2.writedata = writedata; assign bus_w0.writedata = writedata; assign bus_w4.writedata = writedata;
  assign bus_w2.byteenable = byteenable; assign bus_w0.byteenable = byteenable; assign bus_w4.byteenable = byteenable;
  assign bus_w2.read  = rd & (sel == 2'd0);
  assign bus_w2.write = wr & (sel == 2'd0);
  assign bus_w0.read  = rd & (sel == 2'd1);
  assign bus_w0.write = wr & (sel == 2'd1);
  assign bus_w4.read  = rd & (sel == 2'd2);
  assign bus_w4.write = wr & (sel == 2'd2);

  assign waitreq_m  = (sel == 2'd0) ? bus_w2.waitrequest :
                      (sel == 2'd1) ? bus_w0.waitrequest : bus_w4.waitrequest;
  assign readdata_m = (sel == 2'd0) ? bus_w2.readdata :
                      (sel == 2'd1) ? bus_w0.readdata : bus_w4.readdata;

  avalon_ram_slave #(.WAIT_CYCLES(2)) u_w2 (.clk(clk), .reset(reset), .bus(bus_w2), .error(err_w2));
  avalon_ram_slave #(.WAIT_CYCLES(0)) u_w0 (.clk(clk), .reset(reset), .bus(bus_w0), .error(err_w0));
  avalon_ram_slave #(.WAIT_CYCLES(4)) u_w4 (.clk(clk), .reset(reset), .bus(bus_w4), .error(err_w4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Starts at posedge+1 with the selected DUT idle; returns wait cycles and accept-cycle readdata
  task automatic xfer(input logic rd_i, input logic wr_i, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] be,
                      output int waits, output logic [31:0] rdata);
    bit done = 0;
    address = a; writedata = d; byteenable = be; rd = rd_i; wr = wr_i;
    waits = 0; rdata = '0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (!waitreq_m) begin
        rdata = readdata_m;
        done  = 1;
      end else begin
        waits++;
      end
    end
    if (!done) chk("timeout", 32'(waits), 32'd0);
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    reset = 1'b0; sel = 2'd0; rd = 1'b0; wr = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_wreq", 32'(waitreq_m), 32'd1);
    chk("rst_rdata", readdata_m, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_err_w2", 32'(err_w2), 32'd0);
    chk("rst_err_w0", 32'(err_w0), 32'd0);
    chk("rst_err_w4", 32'(err_w4), 32'd0);
    chk("idle_wreq", 32'(waitreq_m), 32'd0);

    // W=2: full write, readback, partial-lane write
    sel = 2'd0;
    xfer(0, 1, 32'hBFC00000, 32'hDEADBEEF, 4'hF, w, r);
    chk("w2_wr_waits", 32'(w), 32'd2);
    xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, w, r);
    chk("w2_rd_waits", 32'(w), 32'd2);
    chk("w2_rd_data", r, 32'hDEADBEEF);
    xfer(0, 1, 32'hBFC00000, 32'h0000AB00, 4'b0010, w, r);
    xfer(1, 0, 32'hBFC00000, 32'h0, 4'b0001, w, r);
    chk("w2_lane_data", r, 32'hDEADABEF);
    chk("w2_err_clean", 32'(err_w2), 32'd0);

    // W=0: wrap-around and read+write collision
    sel = 2'd1;
    xfer(0, 1, 32'hBFC01000, 32'h12345678, 4'hF, w, r);
    chk("w0_wr_waits", 32'(w), 32'd0);
    xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, w, r);
    chk("w0_wrap_data", r, 32'h12345678);
    xfer(0, 1, 32'hBFC00010, 32'h11111111, 4'hF, w, r);
    xfer(1, 1, 32'hBFC00010, 32'hFFFFFFFF, 4'hF, w, r);
    chk("w0_rw_rdata", r, 32'd0);
    chk("w0_rw_err", 32'(err_w0), 32'd1);
    xfer(1, 0, 32'hBFC00010, 32'h0, 4'hF, w, r);
    chk("w0_rw_keep", r, 32'h11111111);

    // W=2: misaligned read, then error stays sticky
    sel = 2'd0;
    xfer(1, 0, 32'hBFC00002, 32'h0, 4'hF, w, r);
    chk("mis_waits", 32'(w), 32'd2);
    chk("mis_rdata", r, 32'd0);
    chk("mis_err", 32'(err_w2), 32'd1);
    xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, w, r);
    chk("mis_clean_data", r, 32'hDEADABEF);
    chk("mis_err_sticky", 32'(err_w2), 32'd1);

    // W=4: byteenable=0 write
    sel = 2'd2;
    xfer(0, 1, 32'hBFC00020, 32'h55AA55AA, 4'hF, w, r);
    chk("w4_wr_waits", 32'(w), 32'd4);
    xfer(0, 1, 32'hBFC00020, 32'h00000000, 4'h0, w, r);
    chk("be0_err", 32'(err_w4), 32'd1);
    xfer(1, 0, 32'hBFC00020, 32'h0, 4'hF, w, r);
    chk("be0_keep", r, 32'h55AA55AA);

    // W=4: reset in the 2nd WAIT cycle of a write
    address = 32'hBFC00020; writedata = 32'hCAFEF00D; byteenable = 4'hF; wr = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    chk("rst_mid_wreq", 32'(waitreq_m), 32'd1);
    @(posedge clk); #1;
    wr = 1'b0;
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_err_w4", 32'(err_w4), 32'd0);
    chk("rst_mid_err_w2", 32'(err_w2), 32'd0);
    chk("rst_mid_err_w0", 32'(err_w0), 32'd0);
    xfer(1, 0, 32'hBFC00020, 32'h0, 4'hF, w, r);
    chk("rst_mid_waits", 32'(w), 32'd4);
    chk("rst_mid_keep", r, 32'h55AA55AA);

    // W=2: request dropped during WAIT
    sel = 2'd0;
    address = 32'hBFC00000; rd = 1'b1;
    @(posedge clk); #1;
    rd = 1'b0;
    @(posedge clk); #1;
    chk("drop_err", 32'(err_w2), 32'd1);
    xfer(1, 0, 32'hBFC00000, 32'h0, 4'hF, w, r);
    chk("drop_after_waits", 32'(w), 32'd2);
    chk("drop_after_data", r, 32'hDEADABEF);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
